// File: rtl/cpu_isa_pkg.sv
// Shared ISA constants and sequencer state encoding for the CPU control-unit side.
package cpu_isa_pkg;

    localparam int OPC_MSB = 8;
    localparam int OPC_LSB = 6;
    localparam int RX_MSB  = 5;
    localparam int RX_LSB  = 3;
    localparam int RY_MSB  = 2;
    localparam int RY_LSB  = 0;

    localparam logic [2:0] OP_MOV  = 3'b000;
    localparam logic [2:0] OP_MOVI = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_MOVO = 3'b100;
    localparam logic [2:0] OP_NOP5 = 3'b101;
    localparam logic [2:0] OP_NOP6 = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    typedef enum logic [2:0] {
        SEQ_IDLE   = 3'd0,
        SEQ_DECODE = 3'd1,
        SEQ_ISSUE  = 3'd2,
        SEQ_WAIT   = 3'd3,
        SEQ_ERR    = 3'd4
    } seq_state_t;

    typedef enum logic [1:0] {
        CLS_ISSUE = 2'd0,
        CLS_NOP   = 2'd1,
        CLS_HALT  = 2'd2
    } op_class_t;

    // Opcodes without a CU meaning are stepped over rather than trapped.
    function automatic op_class_t op_class(input logic [2:0] opc);
        case (opc)
            OP_HALT:          return CLS_HALT;
            OP_NOP5, OP_NOP6: return CLS_NOP;
            default:          return CLS_ISSUE;
        endcase
    endfunction

endpackage

// File: rtl/prog_ram.sv
// Program store: one synchronous write port, two combinational reads (word at pc and pc+1).
module prog_ram
    import cpu_isa_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int DW    = 9
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata0,
    output logic [DW-1:0] o_rdata1
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] w_raddr1;

    always_ff @(posedge clk) begin
        if (i_we)
            r_mem[i_waddr] <= i_wdata;
    end

    // Wraps at the top address; the sequencer never consumes that wrapped word.
    assign w_raddr1 = i_raddr + 1'b1;
    assign o_rdata0 = r_mem[i_raddr];
    assign o_rdata1 = r_mem[w_raddr1];

endmodule

// File: rtl/instr_sequencer.sv
// Instruction-issue engine: walks the loaded program and drives the CU din/run pins,
// advancing on each done from the CU.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// SEQ_IDLE   | not running; program may be loaded; waits for start
// SEQ_DECODE | examine mem[pc]: finish, skip NOP, flag bad movi, or issue
// SEQ_ISSUE  | first run cycle; movi swaps din to its immediate word
// SEQ_WAIT   | run held, timer counting down until done or timeout
// SEQ_ERR    | halted on timeout/program error; only start or reset exits
module instr_sequencer
    import cpu_isa_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int AW      = 4,
    parameter int DW      = 9,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          i_prog_we,
    input  logic [AW-1:0] i_prog_addr,
    input  logic [DW-1:0] i_prog_wdata,
    input  logic [AW:0]   i_prog_len,
    input  logic          i_start,
    input  logic          i_done,
    output logic [DW-1:0] o_din,
    output logic          o_run,
    output logic          o_busy,
    output logic          o_finished,
    output logic          o_timeout_err,
    output logic          o_prog_err,
    output logic [AW:0]   o_pc,
    output logic [7:0]    o_instr_count
);

    localparam int TW = $clog2(TIMEOUT + 1);

    seq_state_t    r_state;
    logic [DW-1:0] r_din;
    logic          r_run;
    logic          r_busy;
    logic          r_finished;
    logic          r_timeout_err;
    logic          r_prog_err;
    logic [AW:0]   r_pc;
    logic [AW:0]   r_len;
    logic [7:0]    r_count;
    logic          r_movi;
    logic [TW-1:0] r_timer;

    logic [DW-1:0] w_rd0;
    logic [DW-1:0] w_rd1;
    logic [2:0]    w_opc;
    op_class_t     w_cls;
    logic          w_is_movi;
    logic [AW:0]   w_pc_inc;
    logic          w_mem_we;

    // Loading is locked out while a program is executing.
    assign w_mem_we = i_prog_we & ~r_busy;

    prog_ram #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_prog_ram (
        .clk      (clk),
        .i_we     (w_mem_we),
        .i_waddr  (i_prog_addr),
        .i_wdata  (i_prog_wdata),
        .i_raddr  (r_pc[AW-1:0]),
        .o_rdata0 (w_rd0),
        .o_rdata1 (w_rd1)
    );

    assign w_opc     = w_rd0[OPC_MSB:OPC_LSB];
    assign w_cls     = op_class(w_opc);
    assign w_is_movi = (w_opc == OP_MOVI);
    assign w_pc_inc  = r_pc + (AW+1)'(1);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state       <= SEQ_IDLE;
            r_din         <= '0;
            r_run         <= 1'b0;
            r_busy        <= 1'b0;
            r_finished    <= 1'b0;
            r_timeout_err <= 1'b0;
            r_prog_err    <= 1'b0;
            r_pc          <= '0;
            r_len         <= '0;
            r_count       <= '0;
            r_movi        <= 1'b0;
            r_timer       <= '0;
        end else begin
            r_finished <= 1'b0;
            case (r_state)
                SEQ_IDLE, SEQ_ERR: begin
                    if (i_start) begin
                        r_pc          <= '0;
                        r_len         <= i_prog_len;
                        r_timeout_err <= 1'b0;
                        r_prog_err    <= 1'b0;
                        r_count       <= '0;
                        if (i_prog_len == '0) begin
                            r_finished <= 1'b1;
                            r_state    <= SEQ_IDLE;
                        end else begin
                            r_busy  <= 1'b1;
                            r_state <= SEQ_DECODE;
                        end
                    end
                end

                SEQ_DECODE: begin
                    if (r_pc == r_len || w_cls == CLS_HALT) begin
                        r_finished <= 1'b1;
                        r_busy     <= 1'b0;
                        r_state    <= SEQ_IDLE;
                    end else if (w_cls == CLS_NOP) begin
                        r_pc <= w_pc_inc;
                    end else if (w_is_movi && w_pc_inc == r_len) begin
                        // movi needs a following immediate word that is not there
                        r_prog_err <= 1'b1;
                        r_busy     <= 1'b0;
                        r_state    <= SEQ_ERR;
                    end else begin
                        r_din   <= w_rd0;
                        r_run   <= 1'b1;
                        r_movi  <= w_is_movi;
                        r_timer <= TW'(TIMEOUT - 1);
                        r_state <= SEQ_ISSUE;
                    end
                end

                SEQ_ISSUE: begin
                    if (r_movi)
                        r_din <= w_rd1;
                    if (r_timer != '0)
                        r_timer <= r_timer - 1'b1;
                    r_state <= SEQ_WAIT;
                end

                SEQ_WAIT: begin
                    if (i_done) begin
                        r_run   <= 1'b0;
                        r_din   <= '0;
                        r_pc    <= r_pc + (r_movi ? (AW+1)'(2) : (AW+1)'(1));
                        if (r_count != 8'hFF)
                            r_count <= r_count + 8'd1;
                        r_state <= SEQ_DECODE;
                    end else if (r_timer == '0) begin
                        // run has been high TIMEOUT cycles counting the ISSUE cycle
                        r_run         <= 1'b0;
                        r_din         <= '0;
                        r_timeout_err <= 1'b1;
                        r_busy        <= 1'b0;
                        r_state       <= SEQ_ERR;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end

                default: begin
                    r_run   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= SEQ_IDLE;
                end
            endcase
        end
    end

    assign o_din         = r_din;
    assign o_run         = r_run;
    assign o_busy        = r_busy;
    assign o_finished    = r_finished;
    assign o_timeout_err = r_timeout_err;
    assign o_prog_err    = r_prog_err;
    assign o_pc          = r_pc;
    assign o_instr_count = r_count;

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Instruction-issue engine that drives the processor control unit's instruction input, run and done handshake from the opposite side.
- Holds a small loadable program memory.
- On start, walks the program and issues one instruction at a time, supplying the immediate word for movi. It waits for done, then advances.
- Sits between the testbench/host load port and the CPU datapath's din/run/done pins.

Parameters:
- DEPTH, 16, program memory words.
- AW, 4, program address width; log2(DEPTH).
- DW, 9, instruction/data word width; fixed opcode in [8:6].
- TIMEOUT, 15, max cycles in WAIT without done before error.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- prog_we  in  1  program write strobe; ignored while busy
- prog_addr  in  AW  program write address
- prog_wdata  in  DW  program write data
- prog_len  in  AW+1  number of valid words, 0..DEPTH; sampled at start
- start  in  1  begin execution at pc=0; ignored while busy
- done  in  1  CU instruction-complete flag
- din  out  DW  instruction/immediate word to CPU
- run  out  1  CU advance enable
- busy  out  1  high from accepted start until finished/error
- finished  out  1  one-cycle pulse on normal completion
- timeout_err  out  1  sticky; done not seen within TIMEOUT
- prog_err  out  1  sticky; movi in last word, no immediate
- pc  out  AW+1  current word address
- instr_count  out  8  completed instructions, saturates at 255

Behaviour:
- Reset values: din=0, run=0, busy=0, finished=0, timeout_err=0, prog_err=0, pc=0, instr_count=0, state=IDLE. Memory array is not reset.
- Reset mid-operation: run drops the next cycle. Memory contents are retained.
- Opcodes [8:6]:
  - 000 mov, 001 movi, 010 add, 011 sub, 100 movo: issued.
  - 101, 110: skipped as NOP (pc+1, no run, not counted).
  - 111: halt.
- All outputs are registered.
- States:
  - IDLE:
    - start with prog_len=0 -> finished pulse, stay IDLE.
    - start otherwise -> latch len, pc=0, clear errors and count, busy=1, go DECODE.
  - DECODE: examine mem[pc].
    - pc==len -> finished=1, busy=0, IDLE.
    - halt -> same as pc==len.
    - NOP -> pc+1, stay DECODE.
    - movi with pc+1==len -> prog_err=1, ERR.
    - valid -> din=mem[pc], run=1, go ISSUE.
  - ISSUE: first cycle with run=1.
    - movi -> din=mem[pc+1], go WAIT. Opcode word is held exactly one cycle.
    - other -> din unchanged, go WAIT.
  - WAIT: run held 1, timer counts.
    - done=1 sampled -> run=0, din=0, instr_count+1 (sat), pc += 2 for movi else 1, go DECODE.
    - timer reaches TIMEOUT without done -> run=0, timeout_err=1, busy=0, ERR.
  - ERR: run=0. Leaves only on start (restart from pc=0, errors cleared) or reset.
- done is ignored outside WAIT, including while in ISSUE. A done arriving in the ISSUE cycle is not consumed.
- Latency:
  - start -> run visible the cycle after DECODE, i.e. 2 edges after start.
  - done -> run low 1 edge later.
  - Next run rises 2 edges after that.
- prog_we while busy: write dropped. prog_we with start in the same cycle in IDLE: write completes, and execution sees the new word.
- pc wraps are impossible by construction: pc is never advanced past len. A movi pc+2 never exceeds len because of the DECODE check.

Decomposition:
- Shared package cpu_isa_pkg:
  - opcode constants OP_MOV, OP_MOVI, OP_ADD, OP_SUB, OP_MOVO, OP_HALT.
  - field positions [8:6], [5:3], [2:0].
  - sequencer state encoding.
- One sub-module, prog_ram: DEPTH x DW, single write port, combinational read port for mem[pc] and mem[pc+1].

Test Plan:
- Load {mov R1,R0 = 9'o010; movo R1 = 9'o410}, len=2, start; done pulsed 3 cycles after each run rise.
  - Required: din 9'o010 then 9'o410; run high until each done.
  - Required: instr_count=2, one finished pulse, busy low.
- Load {movi R2 = 9'o120, imm 9'h05A}, len=2.
  - Required: din=9'o120 for exactly one run cycle, then 9'h05A until done.
  - Required: pc ends at 2, instr_count=1.
- Load {add R0,R1 = 9'o201; 9'o500 NOP; halt 9'o700; mov 9'o000}, len=4.
  - Required: one run burst for the add.
  - Required: finished on the halt, pc=2, mov never issued.
- Issue mov and never assert done.
  - Required: run stays high exactly TIMEOUT=15 cycles, then drops.
  - Required: timeout_err=1, busy=0.
  - Then start again: timeout_err clears and execution runs from pc=0.
- Load movi as the sole word, len=1, start.
  - Required: prog_err=1, run never asserted.
  - Separately, start with len=0: single finished pulse, busy stays 0.
- Assert rstn=0 during WAIT.
  - Required: next cycle run=0, pc=0, instr_count=0.
  - Required: re-start executes the original program unchanged (memory retained); prog_we during busy leaves the memory unmodified.
